// File: rtl/main_memory_responder.sv
// Word-addressed backing memory for the cache strobe/rw/ready protocol: one request
// in flight, fixed per-direction latency, out-of-range accesses flagged with mem_err.
module main_memory_responder #(
    parameter int    DEPTH_LOG2    = 10,
    parameter int    READ_LATENCY  = 4,
    parameter int    WRITE_LATENCY = 4,
    parameter string INIT_FILE     = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_strobe,
    input  logic        mem_rw,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_busy
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    // Counter preload is LAT-1 with LAT clamped into the 8-bit range 1..255.
    function automatic logic [7:0] latency_load(input int lat);
        int clamped;
        clamped = lat;
        if (clamped < 1) begin
            clamped = 1;
        end
        if (clamped > 255) begin
            clamped = 255;
        end
        return 8'(clamped - 1);
    endfunction

    localparam logic [7:0] READ_LOAD  = latency_load(READ_LATENCY);
    localparam logic [7:0] WRITE_LOAD = latency_load(WRITE_LATENCY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              count_reg, count_next;
    logic [DEPTH_LOG2-1:0]   idx_reg;
    logic                    rw_reg;
    logic [31:0]             wdata_reg;
    logic                    oor_reg;
    logic [31:0]             ram_q_reg;
    logic                    rdata_zero_reg;
    logic [31:0]             mem_array [DEPTH];

    logic accept;
    logic complete;
    logic addr_oor;
    logic unused_addr_bits;

    assign accept           = (state_reg == IDLE) && mem_strobe;
    assign complete         = (state_reg == BUSY) && (count_reg == 8'd0);
    assign addr_oor         = |mem_addr[31:DEPTH_LOG2+2];
    assign unused_addr_bits = ^mem_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (mem_strobe) begin
                    state_next = BUSY;
                    count_next = mem_rw ? READ_LOAD : WRITE_LOAD;
                end
            end
            BUSY: begin
                if (count_reg == 8'd0) begin
                    state_next = RESPOND;
                end else begin
                    count_next = count_reg - 8'd1;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = 8'd0;
            end
        endcase
    end

    // Request is captured only at the accept edge; inputs are don't-care afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg   <= '0;
            rw_reg    <= 1'b0;
            wdata_reg <= 32'd0;
            oor_reg   <= 1'b0;
        end else if (accept) begin
            idx_reg   <= mem_addr[DEPTH_LOG2+1:2];
            rw_reg    <= mem_rw;
            wdata_reg <= mem_wdata;
            oor_reg   <= addr_oor;
        end
    end

    // Array port kept free of the async reset so it maps onto block RAM.
    always @(posedge clk) begin
        if (complete && !reset) begin
            if (rw_reg) begin
                ram_q_reg <= mem_array[idx_reg];
            end else if (!oor_reg) begin
                mem_array[idx_reg] <= wdata_reg;
            end
        end
    end

    // Selects zero for mem_rdata after reset or after an out-of-range read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_zero_reg <= 1'b1;
        end else if (complete && rw_reg) begin
            rdata_zero_reg <= oor_reg;
        end
    end

    assign mem_rdata = rdata_zero_reg ? 32'd0 : ram_q_reg;
    assign mem_ready = (state_reg == RESPOND);
    assign mem_err   = (state_reg == RESPOND) && oor_reg;
    assign mem_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: the driver queues expected responses,
// a negedge monitor checks every ready pulse against the queue.
module tb_main_memory_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr = 32'd0;
    logic        mem_strobe = 1'b0;
    logic        mem_rw = 1'b0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;
    logic        mem_busy;

    main_memory_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_strobe (mem_strobe),
        .mem_rw     (mem_rw),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_err    (mem_err),
        .mem_busy   (mem_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata_exp = 32'd0;
    logic        prev_ready = 1'b0;
    int          busy_run = 0;
    int          last_busy_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per ready pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_rdata_exp = 32'd0;
        end
        if (mem_busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_busy_run = busy_run;
            busy_run = 0;
        end
        if (mem_err && !mem_ready) begin
            chk("err_without_ready", {31'd0, mem_err}, 32'd0);
        end
        if (mem_ready) begin
            chk("ready_gap", {31'd0, prev_ready}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no pending request (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                $display("txn %s addr=%h rdata=%h err=%b cycle=%0d",
                         e.rw ? "RD" : "WR", e.addr, mem_rdata, mem_err, cyc);
                chk("latency", 32'(cyc - e.acc), 32'(LAT));
                chk("err", {31'd0, mem_err}, {31'd0, e.err});
                if (e.rw) begin
                    chk("rdata", mem_rdata, e.rdata);
                    last_rdata_exp = e.rdata;
                end else begin
                    chk("rdata_hold", mem_rdata, last_rdata_exp);
                end
            end
        end
        prev_ready = mem_ready;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (mem_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("idle_timeout", 32'd1, 32'd0);
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input logic noisy);
        wait_idle();
        mem_addr   = addr;
        mem_rw     = rw;
        mem_wdata  = wdata;
        mem_strobe = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{rw: rw, addr: addr, rdata: exp_rdata, err: exp_err, acc: cyc});
        if (noisy) begin
            for (int k = 0; k < LAT; k++) begin
                mem_strobe = 1'($urandom_range(0, 1));
                mem_addr   = $urandom;
                mem_wdata  = $urandom;
                mem_rw     = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        mem_strobe = 1'b0;
        wait_idle();
        #1;
        chk("busy_cycles", 32'(last_busy_run), 32'(LAT + 1));
    endtask

    logic [31:0] b2b_addr  [7] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40, 32'h1040, 32'h0};
    logic        b2b_rw    [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] b2b_wdata [7] = '{32'h11110040, 32'h0, 32'h22220044, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [31:0] b2b_exp   [7] = '{32'h0, 32'h11110040, 32'h0, 32'h22220044, 32'h11110040, 32'h0, 32'hCAFE0000};
    logic        b2b_err   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'd0, mem_ready}, 32'd0);
        chk("reset_err", {31'd0, mem_err}, 32'd0);
        chk("reset_busy", {31'd0, mem_busy}, 32'd0);
        chk("reset_rdata", mem_rdata, 32'd0);
        reset = 1'b0;

        // Basic latency
        do_req(32'h00000010, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        do_req(32'h00000010, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Read-after-write, byte offset ignored
        do_req(32'h00000FFC, 1'b0, 32'h12345678, 32'h0, 1'b0, 1'b0);
        do_req(32'h00000000, 1'b0, 32'hCAFE0000, 32'h0, 1'b0, 1'b0);
        do_req(32'h00000FFE, 1'b1, 32'h0, 32'h12345678, 1'b0, 1'b0);
        do_req(32'h00000000, 1'b1, 32'h0, 32'hCAFE0000, 1'b0, 1'b0);

        // Out of range: write suppressed (would alias word 1), read returns zero
        do_req(32'h00000004, 1'b0, 32'h01020304, 32'h0, 1'b0, 1'b0);
        do_req(32'h00001004, 1'b0, 32'hAAAA5555, 32'h0, 1'b1, 1'b0);
        do_req(32'h00000004, 1'b1, 32'h0, 32'h01020304, 1'b0, 1'b0);
        do_req(32'h00001004, 1'b1, 32'h0, 32'h00000000, 1'b1, 1'b0);

        // Inputs scrambled while busy
        do_req(32'h00000030, 1'b0, 32'h5A5A0001, 32'h0, 1'b0, 1'b1);
        do_req(32'h00000010, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        do_req(32'h00000030, 1'b1, 32'h0, 32'h5A5A0001, 1'b0, 1'b0);

        // Reset aborts an accepted write
        do_req(32'h00000020, 1'b0, 32'h11111111, 32'h0, 1'b0, 1'b0);
        wait_idle();
        mem_addr   = 32'h00000020;
        mem_rw     = 1'b0;
        mem_wdata  = 32'h0BADF00D;
        mem_strobe = 1'b1;
        @(posedge clk);
        #1;
        mem_strobe = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("busy_in_reset", {31'd0, mem_busy}, 32'd0);
        chk("ready_in_reset", {31'd0, mem_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rdata_after_reset", mem_rdata, 32'd0);
        chk("busy_after_reset", {31'd0, mem_busy}, 32'd0);
        do_req(32'h00000020, 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0);

        // Back-to-back with strobe held high: accepts every LAT+2 cycles
        wait_idle();
        mem_addr   = b2b_addr[0];
        mem_rw     = b2b_rw[0];
        mem_wdata  = b2b_wdata[0];
        mem_strobe = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            sb.push_back('{rw: b2b_rw[i], addr: b2b_addr[i], rdata: b2b_exp[i], err: b2b_err[i], acc: cyc});
            if (i < 6) begin
                mem_addr  = b2b_addr[i+1];
                mem_rw    = b2b_rw[i+1];
                mem_wdata = b2b_wdata[i+1];
            end else begin
                mem_strobe = 1'b0;
            end
            repeat (LAT + 1) @(posedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
